// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, the default operand width and the divide-by-zero quotient.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Sliced to the instance width at the point of use.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done operand and result bundle of seq_divider.
// master = requester driving operands, slave = the divider.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// purpose: one combinational restoring-division step (compare, conditional subtract)
// latency: 0 cycles, pure combinational
// backpressure: none, evaluated every cycle by the owning FSM
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] diff;

    // partial <= 2*divisor-1, so a successful subtract always fits in WIDTH bits
    // and diff[WIDTH] is exactly the borrow.
    always_comb begin
        diff     = partial - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// purpose: iterative restoring divider, one quotient bit per clock; SEQ_DIVIDER_SIGNED_EN selects two's complement
// latency: WIDTH cycles from accepting edge to done (1 cycle for divide-by-zero)
// backpressure: start is ignored while busy or a divide-by-zero is pending; no queuing
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q, dvd_q, dsr_q;
    logic [WIDTH-1:0] quo_r, rem_r;
    logic             dz_r, dz_pend;
    logic             accept, dsr_zero;
    logic [WIDTH-1:0] rem_step, q_raw;
    logic             q_bit;
    logic [WIDTH-1:0] dvd_load, dsr_load, q_final, r_final;

    assign accept   = bus.start && (state != RUN) && !dz_pend;
    assign dsr_zero = (bus.divisor == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial  ({rem_q, dvd_q[WIDTH-1]}),
        .divisor  (dsr_q),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    // Dividend register doubles as the quotient shift register.
    assign q_raw = {dvd_q[WIDTH-2:0], q_bit};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg, r_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (accept) begin
            q_neg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg <= bus.dividend[WIDTH-1];
        end
    end

    // Magnitude of the most-negative value is representable as unsigned.
    assign dvd_load = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dsr_load = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign q_final  = q_neg ? -q_raw    : q_raw;
    assign r_final  = r_neg ? -rem_step : rem_step;
`else
    assign dvd_load = bus.dividend;
    assign dsr_load = bus.divisor;
    assign q_final  = q_raw;
    assign r_final  = rem_step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Divide-by-zero parks in IDLE for one cycle (busy stays low) so done lands after T1.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (dz_pend)                   state_nxt = DONE;
                else if (accept && !dsr_zero)  state_nxt = RUN;
            end
            RUN:  if (cnt == '0) state_nxt = DONE;
            DONE: state_nxt = (accept && !dsr_zero) ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            dz_pend <= 1'b0;
            quo_r   <= '0;
            rem_r   <= '0;
            dz_r    <= 1'b0;
        end else if (accept) begin
            cnt     <= CW'(WIDTH-1);
            rem_q   <= '0;
            dz_pend <= dsr_zero;
            dvd_q   <= dsr_zero ? bus.dividend : dvd_load;
            dsr_q   <= dsr_load;
        end else if (dz_pend) begin
            dz_pend <= 1'b0;
            quo_r   <= DBZ_QUOTIENT[WIDTH-1:0];
            rem_r   <= dvd_q;
            dz_r    <= 1'b1;
        end else if (state == RUN) begin
            rem_q <= rem_step;
            dvd_q <= q_raw;
            cnt   <= cnt - CW'(1);
            if (cnt == '0) begin
                quo_r <= q_final;
                rem_r <= r_final;
                dz_r  <= 1'b0;
            end
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;
endmodule
